// File: rtl/prio_codec_pkg.sv
// Shared types and constants for the 2-to-4 priority decoder slice.
package prio_codec_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam int unsigned CNT_W           = 3;
  localparam int unsigned HOLD_CYCLES_DEF = 4;

  // One-hot expansion of a 2-bit index.
  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/prio_decoder_2to4_if.sv
// Encoder-side handshake plus decoded outputs of the priority decoder.
interface prio_decoder_2to4_if;
  logic [1:0] q;
  logic       v;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] d;
  logic       d_valid;
  logic       busy;
  logic [3:0] mask;
  logic       mask_clr;

  modport master (
    output q, v, in_valid, mask_clr,
    input  in_ready, d, d_valid, busy, mask
  );

  modport slave (
    input  q, v, in_valid, mask_clr,
    output in_ready, d, d_valid, busy, mask
  );
endinterface

// File: rtl/dec_2to4.sv
// Combinational 2-to-4 decoder; all-zero code when the encoder reports no request.
module dec_2to4
  import prio_codec_pkg::*;
(
  input  logic [1:0] q,
  input  logic       v,
  output logic [3:0] code
);

  // Decode the index only when it is valid.
  always_comb begin
    code = '0;
    if (v) code = onehot4(q);
  end

endmodule

// File: rtl/prio_decoder_2to4.sv
// Registers a decoded one-hot code and holds it for HOLD_CYCLES cycles,
// tracking a sticky mask of every code decoded since the last clear.
module prio_decoder_2to4
  import prio_codec_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = HOLD_CYCLES_DEF
)(
  input  logic                  clk,
  input  logic                  rst_n,
  prio_decoder_2to4_if.slave    bus
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [3:0]       d_r;
  logic [3:0]       d_nxt;
  logic             d_valid_r;
  logic             d_valid_nxt;
  logic [3:0]       mask_r;
  logic [3:0]       mask_nxt;
  logic [3:0]       code;
  logic             xfer;

  dec_2to4 u_dec (
    .q    (bus.q),
    .v    (bus.v),
    .code (code)
  );

  assign xfer         = bus.in_valid && (state == IDLE);
  assign bus.in_ready = (state == IDLE);
  assign bus.busy     = (state == HOLD);
  assign bus.d        = d_r;
  assign bus.d_valid  = d_valid_r;
  assign bus.mask     = mask_r;

  // Next-state, hold counter and output register values.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    d_nxt       = d_r;
    d_valid_nxt = d_valid_r;
    case (state)
      IDLE: begin
        // Outside a hold, d/d_valid last exactly one cycle per transfer.
        d_nxt       = '0;
        d_valid_nxt = 1'b0;
        cnt_nxt     = '0;
        if (xfer) begin
          d_nxt       = code;
          d_valid_nxt = 1'b1;
          if (bus.v) begin
            state_nxt = HOLD;
            cnt_nxt   = CNT_LOAD;
          end
        end
      end
      HOLD: begin
        if (cnt == '0) begin
          state_nxt   = IDLE;
          d_nxt       = '0;
          d_valid_nxt = 1'b0;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Sticky mask: clear first, then OR in the newly accepted code.
  always_comb begin
    mask_nxt = bus.mask_clr ? '0 : mask_r;
    if (xfer && bus.v) mask_nxt = mask_nxt | code;
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      d_r       <= '0;
      d_valid_r <= 1'b0;
      mask_r    <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      d_r       <= d_nxt;
      d_valid_r <= d_valid_nxt;
      mask_r    <= mask_nxt;
    end
  end

endmodule

// File: tb/tb_prio_decoder_2to4.sv
// Scoreboard bench: stimulus queues expected outputs, monitor checks each d_valid cycle.
module tb_prio_decoder_2to4;
  import prio_codec_pkg::*;

  localparam int unsigned H = 4;

  typedef struct packed {
    logic [3:0] d;
    logic [3:0] mask;
    logic       busy;
    logic       in_ready;
  } exp_t;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  exp_t sb[$];

  prio_decoder_2to4_if bus0 ();
  prio_decoder_2to4_if bus1 ();

  prio_decoder_2to4 #(.HOLD_CYCLES(H)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  prio_decoder_2to4 #(.HOLD_CYCLES(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every cycle the DUT presents d_valid, one expectation is consumed.
  always @(negedge clk) begin
    exp_t e;
    exp_t a;
    if (bus0.d_valid === 1'b1) begin
      a = '{d: bus0.d, mask: bus0.mask, busy: bus0.busy, in_ready: bus0.in_ready};
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL mon_extra: got d_valid=1 d=%b expected no output", bus0.d);
      end else begin
        e = sb.pop_front();
        if (a !== e) begin
          errors++;
          $display("FAIL mon_out: got d=%b mask=%b busy=%b rdy=%b expected d=%b mask=%b busy=%b rdy=%b",
                   a.d, a.mask, a.busy, a.in_ready, e.d, e.mask, e.busy, e.in_ready);
        end
      end
    end
  end

  task automatic wait_ready();
    int unsigned n = 0;
    @(negedge clk);
    while (bus0.in_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (bus0.in_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got in_ready=%b expected 1", bus0.in_ready);
    end
  endtask

  // Offer one vector; ed/em are the hand-computed decoded code and mask.
  task automatic send(input logic [1:0] qi, input logic vi, input logic ci,
                      input logic [3:0] ed, input logic [3:0] em);
    wait_ready();
    bus0.q        = qi;
    bus0.v        = vi;
    bus0.mask_clr = ci;
    bus0.in_valid = 1'b1;
    if (vi) begin
      for (int unsigned i = 0; i < H; i++)
        sb.push_back('{d: ed, mask: em, busy: 1'b1, in_ready: 1'b0});
    end else begin
      sb.push_back('{d: ed, mask: em, busy: 1'b0, in_ready: 1'b1});
    end
    @(posedge clk);
    #1 bus0.mask_clr = 1'b0;
  endtask

  task automatic release_bus();
    wait_ready();
    bus0.in_valid = 1'b0;
  endtask

  task automatic drain();
    int unsigned n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", 8'(sb.size()), 8'd0);
    sb.delete();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    bus0.q = '0; bus0.v = 1'b0; bus0.in_valid = 1'b0; bus0.mask_clr = 1'b0;
    bus1.q = '0; bus1.v = 1'b0; bus1.in_valid = 1'b0; bus1.mask_clr = 1'b0;

    // Reset two cycles, release, check idle state.
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_d",        8'(bus0.d),        8'h00);
    chk("rst_d_valid",  8'(bus0.d_valid),  8'h00);
    chk("rst_mask",     8'(bus0.mask),     8'h00);
    chk("rst_in_ready", 8'(bus0.in_ready), 8'h01);
    chk("rst_busy",     8'(bus0.busy),     8'h00);

    // HOLD_CYCLES=1: single-cycle pulse, ready again after one cycle.
    @(negedge clk);
    bus1.q = 2'b01; bus1.v = 1'b1; bus1.in_valid = 1'b1;
    @(posedge clk); #1 bus1.in_valid = 1'b0;
    chk("h1_d",        8'(bus1.d),        8'h02);
    chk("h1_d_valid",  8'(bus1.d_valid),  8'h01);
    chk("h1_busy",     8'(bus1.busy),     8'h01);
    chk("h1_in_ready", 8'(bus1.in_ready), 8'h00);
    @(posedge clk); #1;
    chk("h1_end_d_valid",  8'(bus1.d_valid),  8'h00);
    chk("h1_end_d",        8'(bus1.d),        8'h00);
    chk("h1_end_in_ready", 8'(bus1.in_ready), 8'h01);
    chk("h1_mask",         8'(bus1.mask),     8'h02);

    // Single transfer q=10 held four cycles.
    send(2'b10, 1'b1, 1'b0, 4'b0100, 4'b0100);
    release_bus();
    drain();
    chk("mask_0100", 8'(bus0.mask), 8'h04);

    // Standalone clear.
    @(negedge clk) bus0.mask_clr = 1'b1;
    @(posedge clk); #1 bus0.mask_clr = 1'b0;
    chk("mask_clr_only", 8'(bus0.mask), 8'h00);

    // Back-to-back transfers with in_valid held through HOLD, then a v=0 pulse.
    send(2'b00, 1'b1, 1'b0, 4'b0001, 4'b0001);
    send(2'b01, 1'b1, 1'b0, 4'b0010, 4'b0011);
    send(2'b11, 1'b1, 1'b0, 4'b1000, 4'b1011);
    send(2'b11, 1'b0, 1'b0, 4'b0000, 4'b1011);
    release_bus();
    drain();
    chk("mask_1011", 8'(bus0.mask), 8'h0B);
    chk("idle_busy", 8'(bus0.busy), 8'h00);

    // Clear coinciding with a transfer: clear applies before the OR.
    send(2'b00, 1'b1, 1'b1, 4'b0001, 4'b0001);
    send(2'b10, 1'b1, 1'b0, 4'b0100, 4'b0101);
    send(2'b01, 1'b1, 1'b1, 4'b0010, 4'b0010);
    send(2'b00, 1'b0, 1'b0, 4'b0000, 4'b0010);
    release_bus();
    drain();

    // Reset asserted on the second HOLD cycle of a q=11 transfer.
    wait_ready();
    bus0.q = 2'b11; bus0.v = 1'b1; bus0.in_valid = 1'b1;
    sb.push_back('{d: 4'b1000, mask: 4'b1010, busy: 1'b1, in_ready: 1'b0});
    sb.push_back('{d: 4'b1000, mask: 4'b1010, busy: 1'b1, in_ready: 1'b0});
    @(posedge clk); #1 bus0.in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_d",        8'(bus0.d),        8'h00);
    chk("abort_d_valid",  8'(bus0.d_valid),  8'h00);
    chk("abort_mask",     8'(bus0.mask),     8'h00);
    chk("abort_in_ready", 8'(bus0.in_ready), 8'h01);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", 8'(bus0.in_ready), 8'h01);
    chk("post_rst_busy",     8'(bus0.busy),     8'h00);
    drain();

    // Normal operation resumes after the abort.
    send(2'b01, 1'b1, 1'b0, 4'b0010, 4'b0010);
    release_bus();
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prio_decoder_2to4.md
PRIO_DECODER_2TO4 -- requirements
Module: prio_decoder_2to4

Interface
REQ-001 Parameter HOLD_CYCLES, default 4, number of cycles a decoded one-hot code is driven (legal 1..7).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 q  input  2  encoded index from the 4-to-2 priority encoder.
REQ-005 v  input  1  encoder valid; 1 = some request active, 0 = no request.
REQ-006 in_valid  input  1  upstream offers (q,v) this cycle.
REQ-007 in_ready  output  1  block accepts (q,v) this cycle.
REQ-008 d  output  4  registered one-hot decoded code.
REQ-009 d_valid  output  1  d carries a decoded code this cycle.
REQ-010 busy  output  1  block is in HOLD.
REQ-011 mask  output  4  sticky OR of all one-hot codes decoded since last clear.
REQ-012 mask_clr  input  1  synchronous clear of mask.

Function
REQ-013 Transfer SHALL occur on a rising edge where in_valid=1 and in_ready=1; no transfer otherwise.
REQ-014 in_ready SHALL be 1 in IDLE and 0 in HOLD, driven combinationally from state only.
REQ-015 FSM SHALL have exactly two states: IDLE, HOLD.
REQ-016 IDLE -> HOLD on transfer with v=1; counter loaded with HOLD_CYCLES-1; d <= 1<<q; d_valid <= 1.
REQ-017 Transfer with v=0 SHALL set d <= 4'b0000, d_valid <= 1 for exactly one cycle, stay in IDLE, leave mask unchanged.
REQ-018 In HOLD, d and d_valid SHALL stay constant; counter decrements each cycle; HOLD -> IDLE on the cycle counter is 0.
REQ-019 On HOLD -> IDLE, d <= 4'b0000 and d_valid <= 0 in the same edge.
REQ-020 Latency: accept at edge k -> d_valid high from edge k for HOLD_CYCLES consecutive cycles; next transfer possible no earlier than edge k+HOLD_CYCLES.
REQ-021 HOLD_CYCLES=1 SHALL give a single-cycle d_valid pulse and no HOLD cycle beyond it (in_ready high again after one cycle).
REQ-022 busy SHALL equal (state == HOLD).
REQ-023 On transfer with v=1, mask <= mask | (1<<q).
REQ-024 mask_clr=1 SHALL zero mask; if it coincides with a v=1 transfer, mask <= (1<<q) (clear applied before OR).
REQ-025 in_valid while in HOLD SHALL be ignored; upstream must hold data (no loss, no drop-detect).
REQ-026 d SHALL always be one-hot or zero; never multi-hot.

Reset
REQ-027 On rising edge with rst_n=0: state=IDLE, counter=0, d=4'b0000, d_valid=0, mask=4'b0000; reset overrides all other inputs.
REQ-028 Reset asserted mid-HOLD SHALL abort the hold; in_ready=1 on the first cycle after rst_n returns 1.

Structure
REQ-029 Package prio_codec_pkg SHALL hold the state typedef (IDLE, HOLD), CNT_W=3, and HOLD_CYCLES default.
REQ-030 One combinational sub-module dec_2to4 (q,v -> one-hot) SHALL be instantiated; sequencing stays in the top module.

Verification
REQ-031 rst_n=0 two cycles, then release -> d=0000, d_valid=0, mask=0000, in_ready=1, busy=0.
REQ-032 HOLD_CYCLES=4, transfer q=2'b10,v=1 -> d=0100, d_valid=1 for exactly 4 cycles, in_ready=0 for those 4 cycles, mask=0100.
REQ-033 Transfers q=00,01,11 (v=1) back-to-back as accepted -> d=0001, 0010, 1000 in order; final mask=1011; in_valid held during HOLD not double-counted.
REQ-034 Transfer q=11,v=0 -> d=0000, d_valid single pulse, mask unchanged, state stays IDLE.
REQ-035 mask=0101, mask_clr=1 with transfer q=01,v=1 same edge -> mask=0010.
REQ-036 rst_n=0 on 2nd HOLD cycle of a q=11 transfer -> next edge d=0000, d_valid=0, mask=0000, in_ready=1.
